// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined shifter: op encoding, one mux level,
// and the mapping of mux levels onto register stages.
package shifter_pkg;

    typedef enum logic [2:0] {
        SLL = 3'd0,
        SRL = 3'd1,
        SRA = 3'd2,
        ROL = 3'd3,
        ROR = 3'd4
    } shift_op_t;

    // Levels are evaluated on a wide container so one function serves any BitWidth <= 64.
    localparam int MAX_WIDTH = 64;

    // First mux level owned by a stage; stage s owns levels k with floor(k*stages/log_bw) == s.
    function automatic int stage_first_level(input int stage, input int stages, input int log_bw);
        return (stage * log_bw + stages - 1) / stages;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] shift_level(
        input logic [MAX_WIDTH-1:0] data,
        input logic [2:0]           op,
        input logic                 sign,
        input logic                 enable,
        input int                   k,
        input int                   width
    );
        logic [MAX_WIDTH-1:0] mask;
        logic [MAX_WIDTH-1:0] res;
        int                   sh;
        sh   = 1 << k;
        mask = (MAX_WIDTH'(1) << width) - MAX_WIDTH'(1);
        res  = data;
        if (enable) begin
            case (op)
                SLL:     res = (data << sh) & mask;
                SRL:     res = data >> sh;
                SRA:     res = (data >> sh) | (sign ? (mask & ~(mask >> sh)) : '0);
                ROL:     res = ((data << sh) | (data >> (width - sh))) & mask;
                ROR:     res = ((data >> sh) | (data << (width - sh))) & mask;
                default: res = data;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/shifter_stage.sv
// One register slice of the shifter: applies mux levels FirstLevel..LastLevel to the
// upstream operand and holds the result with its valid bit and handshake.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int BitWidth   = 32,
    parameter int TagWidth   = 5,
    parameter int FirstLevel = 0,
    parameter int LastLevel  = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        up_valid,
    output logic                        up_ready,
    input  logic [BitWidth-1:0]         up_data,
    input  logic [$clog2(BitWidth)-1:0] up_amount,
    input  logic [2:0]                  up_op,
    input  logic                        up_sign,
    input  logic [TagWidth-1:0]         up_tag,
    input  logic                        down_ready,
    output logic                        valid,
    output logic [BitWidth-1:0]         data,
    output logic [$clog2(BitWidth)-1:0] amount,
    output logic [2:0]                  op,
    output logic                        sign,
    output logic [TagWidth-1:0]         tag
);
    localparam int AmtWidth = $clog2(BitWidth);

    logic [MAX_WIDTH-1:0] acc;
    logic [BitWidth-1:0]  data_d;

    always_comb begin
        acc = MAX_WIDTH'(up_data);
        for (int k = FirstLevel; k <= LastLevel; k++) begin
            acc = shift_level(acc, up_op, up_sign,
                              |(up_amount & (AmtWidth'(1) << k)), k, BitWidth);
        end
    end

    assign data_d = acc[BitWidth-1:0];

    // An empty slot always accepts, which collapses bubbles under downstream stall.
    assign up_ready = !valid || down_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= 1'b0;
            data   <= '0;
            amount <= '0;
            op     <= '0;
            sign   <= 1'b0;
            tag    <= '0;
        end else begin
            if (flush) begin
                valid <= 1'b0;
            end else if (up_ready) begin
                valid <= up_valid;
            end
            if (!flush && up_ready && up_valid) begin
                data   <= data_d;
                amount <= up_amount;
                op     <= up_op;
                sign   <= up_sign;
                tag    <= up_tag;
            end
        end
    end

endmodule

// File: rtl/pipelined_shifter.sv
// Flow-controlled barrel shifter for SLL/SRL/SRA/ROL/ROR with the mux levels spread
// over Stages register slices; carries a tag alongside each result.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int BitWidth = 32,
    parameter int Stages   = 2,
    parameter int TagWidth = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BitWidth-1:0]         in_data,
    input  logic [$clog2(BitWidth)-1:0] in_amount,
    input  logic [2:0]                  in_op,
    input  logic [TagWidth-1:0]         in_tag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BitWidth-1:0]         out_data,
    output logic [TagWidth-1:0]         out_tag
);
    localparam int LogBw = $clog2(BitWidth);

    // Index 0 is the input port; index s+1 is the register of stage s.
    logic                vld [0:Stages];
    logic                rdy [0:Stages];
    logic [BitWidth-1:0] dat [0:Stages];
    logic [LogBw-1:0]    amt [0:Stages];
    logic [2:0]          opc [0:Stages];
    logic                sgn [0:Stages];
    logic [TagWidth-1:0] tg  [0:Stages];

    assign vld[0]      = in_valid;
    assign dat[0]      = in_data;
    assign amt[0]      = in_amount;
    assign opc[0]      = in_op;
    assign sgn[0]      = in_data[BitWidth-1];
    assign tg[0]       = in_tag;
    assign rdy[Stages] = out_ready;

    for (genvar s = 0; s < Stages; s++) begin : g_stage
        shifter_stage #(
            .BitWidth  (BitWidth),
            .TagWidth  (TagWidth),
            .FirstLevel(stage_first_level(s, Stages, LogBw)),
            .LastLevel (stage_first_level(s + 1, Stages, LogBw) - 1)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .up_valid  (vld[s]),
            .up_ready  (rdy[s]),
            .up_data   (dat[s]),
            .up_amount (amt[s]),
            .up_op     (opc[s]),
            .up_sign   (sgn[s]),
            .up_tag    (tg[s]),
            .down_ready(rdy[s+1]),
            .valid     (vld[s+1]),
            .data      (dat[s+1]),
            .amount    (amt[s+1]),
            .op        (opc[s+1]),
            .sign      (sgn[s+1]),
            .tag       (tg[s+1])
        );
    end

    assign in_ready  = !flush && rdy[0];
    assign out_valid = vld[Stages];
    assign out_data  = dat[Stages];
    assign out_tag   = tg[Stages];

    // The last slice's control fields have no consumer once every level is applied.
    logic unused_tail;
    assign unused_tail = ^{amt[Stages], opc[Stages], sgn[Stages]};

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed bench for pipelined_shifter: Stages=2 main instance plus Stages=1 and
// Stages=5 instances for latency and fill checks.
module tb_pipelined_shifter;
    localparam logic [2:0] OP_SLL = 3'd0;
    localparam logic [2:0] OP_SRL = 3'd1;
    localparam logic [2:0] OP_SRA = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] in_data = '0;
    logic [4:0]  in_amount = '0;
    logic [2:0]  in_op = '0;
    logic [4:0]  in_tag = '0;
    logic        iv [3];
    logic        ir [3];
    logic        ov [3];
    logic        ordy [3];
    logic [31:0] od [3];
    logic [4:0]  ot [3];
    int          lat_exp [3] = '{2, 1, 5};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;

    logic [31:0] mon_d [$];
    logic [4:0]  mon_t [$];
    int          mon_c [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    pipelined_shifter #(.BitWidth(32), .Stages(2), .TagWidth(5)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(in_data), .in_amount(in_amount),
        .in_op(in_op), .in_tag(in_tag),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_tag(ot[0])
    );

    pipelined_shifter #(.BitWidth(32), .Stages(1), .TagWidth(5)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(in_data), .in_amount(in_amount),
        .in_op(in_op), .in_tag(in_tag),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_tag(ot[1])
    );

    pipelined_shifter #(.BitWidth(32), .Stages(5), .TagWidth(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(iv[2]), .in_ready(ir[2]), .in_data(in_data), .in_amount(in_amount),
        .in_op(in_op), .in_tag(in_tag),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .out_tag(ot[2])
    );

    // Records every result the Stages=2 instance hands over (sampled mid-cycle).
    always @(negedge clk) begin
        if (rst_n && ov[0] && ordy[0]) begin
            mon_d.push_back(od[0]);
            mon_t.push_back(ot[0]);
            mon_c.push_back(cyc_cnt);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic mon_clear();
        mon_d.delete();
        mon_t.delete();
        mon_c.delete();
    endtask

    // Called just after a rising edge; returns just after the edge that accepts the op.
    task automatic send(input int di, input logic [2:0] op, input logic [31:0] data,
                        input logic [4:0] amt, input logic [4:0] tag, output int waits);
        in_op = op;
        in_data = data;
        in_amount = amt;
        in_tag = tag;
        iv[di] = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!ir[di] && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!ir[di]) check("send_timeout", ir[di], 1);
        @(posedge clk);
        #1;
        iv[di] = 1'b0;
    endtask

    task automatic run_op(input int di, input string name, input logic [2:0] op,
                          input logic [31:0] data, input logic [4:0] amt,
                          input logic [4:0] tag, input logic [31:0] exp);
        int waits;
        int lat;
        send(di, op, data, amt, tag, waits);
        lat = 1;
        while (!ov[di] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_lat"}, lat, lat_exp[di]);
        check({name, "_data"}, od[di], exp);
        check({name, "_tag"}, ot[di], tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int drops;
        int nacc;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0;
            ordy[i] = 1'b1;
        end

        // Reset state
        #12;
        check("rst_ov", ov[0], 0);
        check("rst_od", od[0], 0);
        check("rst_ot", ot[0], 0);
        check("rst_ov5", ov[2], 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ir2", ir[0], 1);
        check("rst_ir1", ir[1], 1);
        check("rst_ir5", ir[2], 1);

        // Directed vectors on Stages=2
        run_op(0, "sra3", OP_SRA, 32'hA000_0000, 5'd3, 5'd1, 32'hF400_0000);
        run_op(0, "srl3", OP_SRL, 32'hA000_0000, 5'd3, 5'd2, 32'h1400_0000);
        run_op(0, "ror4", OP_ROR, 32'h0000_000F, 5'd4, 5'd3, 32'hF000_0000);
        run_op(0, "rol31", OP_ROL, 32'h0000_000F, 5'd31, 5'd4, 32'h8000_0007);
        run_op(0, "sll31", OP_SLL, 32'd10, 5'd31, 5'd5, 32'h0000_0000);
        run_op(0, "sra_pos", OP_SRA, 32'h7000_0000, 5'd4, 5'd6, 32'h0700_0000);
        run_op(0, "sra31", OP_SRA, 32'h8000_0000, 5'd31, 5'd7, 32'hFFFF_FFFF);
        run_op(0, "op6_pass", 3'd6, 32'h1234_5678, 5'd9, 5'd8, 32'h1234_5678);
        for (int j = 0; j < 8; j++) begin
            run_op(0, "amt0", j[2:0], 32'hDEAD_BEEF, 5'd0, j[4:0], 32'hDEAD_BEEF);
        end

        // Back-to-back stream
        mon_clear();
        drops = 0;
        for (int i = 0; i < 32; i++) begin
            send(0, OP_SLL, 32'd1, i[4:0], i[4:0], w);
            drops += w;
        end
        repeat (4) @(posedge clk);
        #1;
        check("stream_in_ready_drops", drops, 0);
        check("stream_count", mon_d.size(), 32);
        for (int i = 0; i < 32 && i < mon_d.size(); i++) begin
            check("stream_data", mon_d[i], 32'd1 << i);
            check("stream_tag", mon_t[i], i);
        end
        if (mon_c.size() == 32) check("stream_rate", mon_c[31] - mon_c[0], 31);

        // Backpressure
        mon_clear();
        ordy[0] = 1'b0;
        nacc = 0;
        for (int c = 0; c < 5; c++) begin
            in_op = OP_SRL;
            in_data = 32'h8000_0000;
            in_amount = nacc[4:0];
            in_tag = nacc[4:0];
            iv[0] = 1'b1;
            @(negedge clk);
            if (ir[0]) nacc++;
            if (ov[0]) begin
                check("stall_data", od[0], 32'h8000_0000);
                check("stall_tag", ot[0], 0);
            end
            @(posedge clk);
            #1;
        end
        check("stall_accepted", nacc, 2);
        check("stall_in_ready", ir[0], 0);
        check("stall_out_valid", ov[0], 1);
        ordy[0] = 1'b1;
        for (int k = nacc; k < 5; k++) begin
            send(0, OP_SRL, 32'h8000_0000, k[4:0], k[4:0], w);
        end
        repeat (6) @(posedge clk);
        #1;
        check("bp_count", mon_d.size(), 5);
        for (int k = 0; k < 5 && k < mon_d.size(); k++) begin
            check("bp_data", mon_d[k], 32'h8000_0000 >> k);
            check("bp_tag", mon_t[k], k);
        end

        // Flush with two ops in flight and a concurrent input
        mon_clear();
        ordy[0] = 1'b0;
        send(0, OP_ROL, 32'h1, 5'd1, 5'd10, w);
        send(0, OP_ROL, 32'h1, 5'd2, 5'd11, w);
        flush = 1'b1;
        iv[0] = 1'b1;
        in_tag = 5'd12;
        in_data = 32'h5555_5555;
        @(negedge clk);
        check("flush_in_ready", ir[0], 0);
        check("flush_ov_before", ov[0], 1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        iv[0] = 1'b0;
        check("flush_ov", ov[0], 0);
        ordy[0] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("flush_no_results", mon_d.size(), 0);
        run_op(0, "post_flush", OP_SRA, 32'hA000_0000, 5'd3, 5'd13, 32'hF400_0000);

        // Asynchronous reset mid-stream
        in_op = OP_SLL;
        in_data = 32'h3;
        in_amount = 5'd4;
        in_tag = 5'd20;
        iv[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3;
        check("pre_reset_ov", ov[0], 1);
        check("pre_reset_od", od[0], 32'h30);
        rst_n = 1'b0;
        #1;
        check("reset_ov", ov[0], 0);
        check("reset_od", od[0], 0);
        check("reset_ot", ot[0], 0);
        iv[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_ir", ir[0], 1);
        run_op(0, "post_reset", OP_ROR, 32'h0000_000F, 5'd4, 5'd21, 32'hF000_0000);

        // Stages=1 and Stages=5
        run_op(1, "s1_sra", OP_SRA, 32'hA000_0000, 5'd3, 5'd1, 32'hF400_0000);
        run_op(1, "s1_ror", OP_ROR, 32'h0000_000F, 5'd4, 5'd2, 32'hF000_0000);
        run_op(2, "s5_sra", OP_SRA, 32'hA000_0000, 5'd3, 5'd1, 32'hF400_0000);
        run_op(2, "s5_ror", OP_ROR, 32'h0000_000F, 5'd4, 5'd2, 32'hF000_0000);
        run_op(2, "s5_sra31", OP_SRA, 32'h8000_0000, 5'd31, 5'd3, 32'hFFFF_FFFF);
        run_op(2, "s5_rol31", OP_ROL, 32'h0000_000F, 5'd31, 5'd4, 32'h8000_0007);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
